// File: rtl/eth_tx_fcs_inserter.sv
// Transmit FCS inserter: passes frame bytes through, optionally zero-pads short frames,
// and appends the IEEE 802.3 CRC-32. Optional padding is compiled in with ETH_TX_PAD_EN.
module eth_tx_fcs_inserter #(
    parameter int MIN_FRAME = 60
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    input  logic       tx_last_i,
    output logic       tx_ready_o,
    output logic [7:0] out_data_o,
    output logic       out_valid_o,
    output logic       out_last_o,
    input  logic       out_ready_i,
    output logic       busy_o
);

    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT = 32'hffffffff;

    if (MIN_FRAME < 1 || MIN_FRAME > 63) begin : g_bad_min_frame
        $error("MIN_FRAME must be within 1..63");
    end

`ifdef ETH_TX_PAD_EN
    localparam logic [5:0] MIN_CNT = MIN_FRAME[5:0];
`endif

    typedef enum logic [1:0] {IDLE, DATA, PAD, FCS} state_t;

    state_t      state;
    logic [31:0] crc_reg;
    logic [5:0]  byte_cnt;
    logic [5:0]  byte_cnt_inc;
    logic [1:0]  fcs_idx;
    logic [7:0]  fcs_byte;
    logic        pad_needed;
    logic        in_beat;
    logic        out_beat;

    // Data bit d[k] meets crc[31] on step k, i.e. D[7-i] pairs with crc[24+i].
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++) begin
            if (r[31] ^ d[k]) r = {r[30:0], 1'b0} ^ CRC_POLY;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    always_comb begin
        byte_cnt_inc = (byte_cnt == 6'd63) ? byte_cnt : byte_cnt + 6'd1;
        fcs_byte = '0;
        for (int i = 0; i < 8; i++) fcs_byte[7-i] = ~crc_reg[24+i];
`ifdef ETH_TX_PAD_EN
        pad_needed = (byte_cnt_inc < MIN_CNT);
`else
        pad_needed = 1'b0;
`endif
    end

    // Valid/ready: a beat happens on a side when valid & ready are both high at the clock
    // edge; the producer holds data/valid stable while stalled. Payload is combinational
    // pass-through, so source ready is simply the serializer's ready.
    always_comb begin
        tx_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_data_o  = 8'h00;
        case (state)
            IDLE, DATA: begin
                tx_ready_o  = out_ready_i;
                out_valid_o = tx_valid_i;
                out_data_o  = tx_data_i;
            end
`ifdef ETH_TX_PAD_EN
            PAD: begin
                out_valid_o = 1'b1;
                out_data_o  = 8'h00;
            end
`endif
            FCS: begin
                out_valid_o = 1'b1;
                out_data_o  = fcs_byte;
            end
            default: ;
        endcase
    end

    assign in_beat    = tx_valid_i & tx_ready_o;
    assign out_beat   = out_valid_o & out_ready_i;
    assign out_last_o = (state == FCS) && (fcs_idx == 2'd3);
    assign busy_o     = (state != IDLE);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            crc_reg  <= CRC_INIT;
            byte_cnt <= 6'd0;
            fcs_idx  <= 2'd0;
        end else begin
            case (state)
                IDLE, DATA: begin
                    if (in_beat) begin
                        crc_reg  <= crc_byte(crc_reg, tx_data_i);
                        byte_cnt <= byte_cnt_inc;
                        fcs_idx  <= 2'd0;
                        if (tx_last_i) state <= pad_needed ? PAD : FCS;
                        else           state <= DATA;
                    end
                end
`ifdef ETH_TX_PAD_EN
                PAD: begin
                    if (out_beat) begin
                        crc_reg  <= crc_byte(crc_reg, 8'h00);
                        byte_cnt <= byte_cnt_inc;
                        if (byte_cnt_inc == MIN_CNT) state <= FCS;
                    end
                end
`endif
                FCS: begin
                    if (out_beat) begin
                        crc_reg <= {crc_reg[23:0], 8'hff};
                        fcs_idx <= fcs_idx + 2'd1;
                        if (fcs_idx == 2'd3) begin
                            state    <= IDLE;
                            crc_reg  <= CRC_INIT;
                            byte_cnt <= 6'd0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_fcs_inserter.sv
// Bench for eth_tx_fcs_inserter: random frames against a reflected CRC-32 reference,
// with a scoreboard queue and a receive-side residue check on every completed frame.
module tb_eth_tx_fcs_inserter;

    localparam int MIN_FRAME = 60;

    logic       Clk;
    logic       Reset;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_last_i;
    logic       tx_ready_o;
    logic [7:0] out_data_o;
    logic       out_valid_o;
    logic       out_last_o;
    logic       out_ready_i;
    logic       busy_o;

    eth_tx_fcs_inserter #(.MIN_FRAME(MIN_FRAME)) dut (
        .Clk(Clk), .Reset(Reset),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_last_i(tx_last_i),
        .tx_ready_o(tx_ready_o),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_last_o(out_last_o),
        .out_ready_i(out_ready_i), .busy_o(busy_o)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         out_beats = 0;
    int         last_cyc = 0;
    int         exp_len = 0;
    int         rdy_mode = 0;
    logic       pend = 1'b0;
    logic       b2b_arm = 1'b0;
    logic [8:0] exp_q[$];
    logic [7:0] pay[$];

    // ---------------- clock / reset ----------------
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] crc_refl_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] c);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = c[31-i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected wire image: payload, zero pad up to MIN_FRAME (if built), then ~CRC LSB first.
    task automatic push_expected();
        logic [7:0]  f[$];
        logic [31:0] crc;
        f = pay;
`ifdef ETH_TX_PAD_EN
        while (f.size() < MIN_FRAME) f.push_back(8'h00);
`endif
        crc = 32'hffffffff;
        foreach (f[i]) begin
            crc = crc_refl_upd(crc, f[i]);
            exp_q.push_back({1'b0, f[i]});
        end
        crc = ~crc;
        for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), crc[8*k +: 8]});
        exp_len = f.size() + 4;
    endtask

    // ---------------- drivers ----------------
    initial begin
        out_ready_i = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            case (rdy_mode)
                0: out_ready_i = 1'b1;
                1: out_ready_i = ~out_ready_i;
                default: out_ready_i = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic send_payload(input int gap_pct);
        int   n;
        logic got;
        push_expected();
        for (int i = 0; i < pay.size(); i++) begin
            if (gap_pct > 0) begin
                while ($urandom_range(0, 99) < gap_pct) begin
                    tx_valid_i = 1'b0;
                    tx_data_i  = 8'($urandom);
                    tx_last_i  = 1'($urandom);
                    @(posedge Clk);
                    #1;
                end
            end
            tx_valid_i = 1'b1;
            tx_data_i  = pay[i];
            tx_last_i  = (i == pay.size() - 1);
            n = 0;
            got = 1'b0;
            while (!got && n < 1000) begin
                @(negedge Clk);
                got = tx_ready_o;
                @(posedge Clk);
                #1;
                n++;
            end
            if (!got) chk("tx_accept_timeout", 32'd0, 32'd1);
        end
        tx_valid_i = 1'b0;
        tx_last_i  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge Clk);
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        @(posedge Clk);
        #1;
    endtask

    task automatic fill_random(input int len);
        pay.delete();
        for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [31:0] acc;
        logic [8:0]  e;
        acc = 32'hffffffff;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                acc = 32'hffffffff;
            end else if (out_valid_o && out_ready_i) begin
                out_beats++;
                if (b2b_arm && pend) chk("b2b_gap_cycles", 32'(cyc - last_cyc), 32'd1);
                pend = 1'b0;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got %h expected no output", {out_last_o, out_data_o});
                end else begin
                    e = exp_q.pop_front();
                    chk("out_last_data", 32'({out_last_o, out_data_o}), 32'(e));
                end
                acc = crc_refl_upd(acc, out_data_o);
                if (out_last_o) begin
                    chk("rx_residue", bitrev32(acc), 32'hc704dd7b);
                    acc = 32'hffffffff;
                    pend = 1'b1;
                    last_cyc = cyc;
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int n;
        int target;
        Reset      = 1'b1;
        tx_valid_i = 1'b0;
        tx_last_i  = 1'b0;
        tx_data_i  = 8'h5A;
        #3;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_out_last", 32'(out_last_o), 32'd0);
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready_o), 32'(out_ready_i));
        chk("rst_passthru", 32'(out_data_o), 32'h5A);
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;

        // 60-byte counting frame, no stalls
        pay.delete();
        for (int i = 0; i < 60; i++) pay.push_back(8'(i));
        send_payload(0);
        wait_drain();

        // 1-byte frame (padded to MIN_FRAME when padding is built)
        pay.delete();
        pay.push_back(8'hAA);
        send_payload(0);
        wait_drain();

        // 100-byte frame with alternating serializer ready and source gaps
        rdy_mode = 1;
        fill_random(100);
        send_payload(30);
        wait_drain();
        rdy_mode = 0;

        // Reset while the second FCS byte is pending
        fill_random(10);
        target = out_beats;
        send_payload(0);
        target = target + exp_len - 3;
        n = 0;
        while (out_beats != target && n < 2000) begin
            @(posedge Clk);
            #1;
            n++;
        end
        chk("fcs1_reached", 32'(out_beats), 32'(target));
        Reset = 1'b1;
        exp_q.delete();
        #1;
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_out_last", 32'(out_last_o), 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        chk("post_abort_busy", 32'(busy_o), 32'd0);
        chk("post_abort_valid", 32'(out_valid_o), 32'd0);
        @(posedge Clk);
        #1;
        fill_random(64);
        send_payload(0);
        wait_drain();

        // Back-to-back 64-byte frames, source valid held high
        pend    = 1'b0;
        b2b_arm = 1'b1;
        fill_random(64);
        send_payload(0);
        fill_random(64);
        send_payload(0);
        wait_drain();
        b2b_arm = 1'b0;

        // Random lengths, random ready, random gaps
        rdy_mode = 2;
        for (int f = 0; f < 16; f++) begin
            fill_random($urandom_range(1, 90));
            send_payload($urandom_range(0, 40));
        end
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
